// File: rtl/gray_decode_scheduler.sv
// Round-robin shared bit-serial Gray-to-binary decoder: one requester is granted
// at a time, its word is decoded MSB-first, and the result is reported with a done pulse.
module gray_decode_scheduler #(
  parameter int W    = 4,
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*W-1:0]         gray_in,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [W-1:0]              bin_out
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(W);

  // Handshake: a requester holds req and its gray_in slice stable until it sees
  // gnt (one-cycle pulse), then drops req; a req still high in IDLE is a new job.
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [W-1:0]    g_reg;
  logic [W-1:0]    res;
  logic [CW-1:0]   cnt;
  logic            prev;

  logic            found;
  logic [IDW-1:0]  win_id;
  logic [W-1:0]    win_word;
  logic            bit_b;
  logic [W-1:0]    res_next;
  int              idx;

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    found    = 1'b0;
    win_id   = '0;
    win_word = '0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win_id   = IDW'(idx);
        win_word = gray_in[idx*W +: W];
      end
    end
  end

  always_comb begin
    bit_b         = prev ^ g_reg[cnt];
    res_next      = res;
    res_next[cnt] = bit_b;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      bin_out <= '0;
      rr_ptr  <= IDW'(NREQ-1);
      g_reg   <= '0;
      res     <= '0;
      cnt     <= '0;
      prev    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (found) begin
            g_reg  <= win_word;
            rr_ptr <= win_id;
            gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win_id;
            cnt    <= CW'(W-1);
            prev   <= 1'b0;
            state  <= CONV;
          end
        end
        CONV: begin
          gnt  <= '0;
          prev <= bit_b;
          res  <= res_next;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            bin_out <= res_next;
            done_id <= rr_ptr;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
